input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_cond_pkg.sv | 27 ++
 rtl/debounce_ch.sv | 114 +++++++++++
 rtl/input_conditioner.sv | 54 +++++
 tb/tb_input_conditioner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_cond_pkg
// Purpose  : Shared definitions for the input conditioner: per-channel
//            debounce FSM state encoding, default parameter values and a
//            helper that sizes the debounce counter.
// Revision : 1.0 - initial release
// ============================================================================
package input_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHECK_HI  = 2'b01,
        STABLE_HI = 2'b10,
        CHECK_LO  = 2'b11
    } db_state_e;

    localparam int DB_CYCLES_DEF   = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // Counter must hold DB_CYCLES-1; one spare bit keeps DB_CYCLES=1 legal.
    function automatic int cnt_width(input int db_cycles);
        return $clog2(db_cycles) + 1;
    endfunction

endpackage : input_cond_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : debounce_ch
// Purpose  : One conditioning channel: SYNC_STAGES-deep synchronizer followed
//            by a four-state debounce FSM with a saturating qualify counter.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous, active-high reset
//            raw_i    - asynchronous raw input
//            out_o    - conditioned output (level, or pulse when
//                       INPUT_COND_PULSE_EN is defined)
//            bounce_o - one-cycle pulse when a change is rejected as bounce
// Config   : INPUT_COND_PULSE_EN - out_o becomes a one-cycle pulse on each
//            qualified rising change instead of a level.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_ch
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic out_o,
    output logic bounce_o
);

    localparam int             CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q;
    logic [CW-1:0]          cnt_q;
    logic                   out_q;
    logic                   bounce_q;

    // Synchronizer: raw enters bit 0, qualified sample leaves the top bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Outputs are written on the same edge as the state change they reflect,
    // so the output register tracks the state register with no extra cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            bounce_q <= 1'b0;
`ifdef INPUT_COND_PULSE_EN
            out_q    <= 1'b0;
`endif
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_q <= CHECK_HI;
                        cnt_q   <= '0;
                    end
                end
                CHECK_HI: begin
                    if (!s) begin
                        state_q  <= STABLE_LO;
                        bounce_q <= 1'b1;
                    end else if (cnt_q == CNT_MAX) begin
                        // Only a qualified rise sets the output; a rejected
                        // release (CHECK_LO -> STABLE_HI) never pulses.
                        state_q <= STABLE_HI;
                        out_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_q <= CHECK_LO;
                        cnt_q   <= '0;
                    end
                end
                CHECK_LO: begin
                    if (s) begin
                        state_q  <= STABLE_HI;
                        bounce_q <= 1'b1;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_LO;
`ifndef INPUT_COND_PULSE_EN
                        out_q   <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                end
            endcase
        end
    end

    assign out_o    = out_q;
    assign bounce_o = bounce_q;

endmodule : debounce_ch
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Synchronizes and debounces two independent asynchronous inputs
//            (push-buttons/sensors) for a downstream FSM.
// Ports    : clk              - rising-edge clock
//            reset            - asynchronous, active-high reset
//            raw_a, raw_b     - asynchronous raw inputs
//            a_out, b_out     - conditioned outputs (registered)
//            a_bounce,b_bounce- one-cycle pulse on a rejected change
// Config   : INPUT_COND_PULSE_EN - a_out/b_out become one-cycle pulses on a
//            qualified rising change instead of levels.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic a_out,
    output logic b_out,
    output logic a_bounce,
    output logic b_bounce
);

    debounce_ch #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_a (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (raw_a),
        .out_o    (a_out),
        .bounce_o (a_bounce)
    );

    debounce_ch #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_b (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (raw_b),
        .out_o    (b_out),
        .bounce_o (b_bounce)
    );

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Purpose  : Directed self-checking bench for input_conditioner. A default
//            instance (DB_CYCLES=4, SYNC_STAGES=2) and a fast instance
//            (DB_CYCLES=1, SYNC_STAGES=3) share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic raw_a, raw_b;
    logic a_out, b_out, a_bounce, b_bounce;
    logic raw_a2, raw_b2;
    logic a_out2, b_out2, a_bounce2, b_bounce2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_conditioner u_dut (
        .clk      (clk),
        .reset    (reset),
        .raw_a    (raw_a),
        .raw_b    (raw_b),
        .a_out    (a_out),
        .b_out    (b_out),
        .a_bounce (a_bounce),
        .b_bounce (b_bounce)
    );

    input_conditioner #(.DB_CYCLES(1), .SYNC_STAGES(3)) u_fast (
        .clk      (clk),
        .reset    (reset),
        .raw_a    (raw_a2),
        .raw_b    (raw_b2),
        .a_out    (a_out2),
        .b_out    (b_out2),
        .a_bounce (a_bounce2),
        .b_bounce (b_bounce2)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0; raw_a2 = 1'b0; raw_b2 = 1'b0;
        tick(); tick();
        checks++;
        if ({a_out, b_out, a_bounce, b_bounce} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000", {a_out, b_out, a_bounce, b_bounce});
        end
        checks++;
        if ({a_out2, b_out2, a_bounce2, b_bounce2} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs_fast: got %b expected 0000", {a_out2, b_out2, a_bounce2, b_bounce2});
        end
        reset = 1'b0;
        tick();
    endtask

    // raw_a rises and is held: a_out rises on edge 7, falls 7 edges after release.
    task automatic test_level();
        logic exp;
        raw_a = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp = (i >= 7);
            checks++;
            if (a_out !== exp || a_bounce !== 1'b0) begin
                failures++;
                $display("FAIL level_rise edge%0d: a_out=%b a_bounce=%b expected a_out=%b a_bounce=0", i, a_out, a_bounce, exp);
            end
        end
        raw_a = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp = (i < 7);
            checks++;
            if (a_out !== exp || a_bounce !== 1'b0) begin
                failures++;
                $display("FAIL level_fall edge%0d: a_out=%b a_bounce=%b expected a_out=%b a_bounce=0", i, a_out, a_bounce, exp);
            end
        end
    endtask

    // raw_a high for two edges -> s high two cycles -> rejected on edge 5.
    task automatic test_bounce();
        int pulses = 0;
        logic exp;
        raw_a = 1'b1;
        tick(); tick();
        raw_a = 1'b0;
        for (int i = 3; i <= 12; i++) begin
            tick();
            exp = (i == 5);
            pulses += int'(a_bounce);
            checks++;
            if (a_bounce !== exp || a_out !== 1'b0) begin
                failures++;
                $display("FAIL bounce edge%0d: a_bounce=%b a_out=%b expected a_bounce=%b a_out=0", i, a_bounce, a_out, exp);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL bounce_count: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        logic exp;
        raw_a = 1'b1; raw_b = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i >= 7);
            checks++;
            if (a_out !== exp || b_out !== exp || a_bounce !== 1'b0 || b_bounce !== 1'b0) begin
                failures++;
                $display("FAIL simultaneous edge%0d: a_out=%b b_out=%b bounces=%b%b expected %b %b 00", i, a_out, b_out, a_bounce, b_bounce, exp, exp);
            end
        end
        raw_a = 1'b0; raw_b = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i < 7);
            checks++;
            if (a_out !== exp || b_out !== exp) begin
                failures++;
                $display("FAIL simultaneous_fall edge%0d: a_out=%b b_out=%b expected %b %b", i, a_out, b_out, exp, exp);
            end
        end
    endtask

    // After 5 edges channel A is in CHECK_HI with cnt=2; reset aborts it.
    task automatic test_reset_mid_check();
        raw_a = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        checks++;
        if (a_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_check_pre: a_out=%b expected 0", a_out);
        end
        @(negedge clk);
        reset = 1'b1; raw_a = 1'b0;
        #1;
        checks++;
        if ({a_out, b_out, a_bounce, b_bounce} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_check_async: outputs=%b expected 0000", {a_out, b_out, a_bounce, b_bounce});
        end
        tick(); tick();
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (a_out !== 1'b0 || a_bounce !== 1'b0) begin
                failures++;
                $display("FAIL mid_check_after edge%0d: a_out=%b a_bounce=%b expected 0 0", i, a_out, a_bounce);
            end
        end
    endtask

    // raw_a held high through reset release qualifies from the first edge.
    task automatic test_high_through_reset();
        logic exp;
        reset = 1'b1; raw_a = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i >= 7);
            checks++;
            if (a_out !== exp) begin
                failures++;
                $display("FAIL high_through_reset edge%0d: a_out=%b expected %b", i, a_out, exp);
            end
        end
        raw_a = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
    endtask

    task automatic test_pulse_mode();
        logic exp;
        raw_b = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
`ifdef INPUT_COND_PULSE_EN
            exp = (i == 7);
`else
            exp = (i >= 7);
`endif
            checks++;
            if (b_out !== exp || b_bounce !== 1'b0) begin
                failures++;
                $display("FAIL b_hold edge%0d: b_out=%b b_bounce=%b expected %b 0", i, b_out, b_bounce, exp);
            end
        end
        raw_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
`ifdef INPUT_COND_PULSE_EN
            exp = 1'b0;
`else
            exp = (i < 7);
`endif
            checks++;
            if (b_out !== exp) begin
                failures++;
                $display("FAIL b_release edge%0d: b_out=%b expected %b", i, b_out, exp);
            end
        end
    endtask

    // DB_CYCLES=1, SYNC_STAGES=3: latency 3+1+1 = 5 edges each way.
    task automatic test_fast_config();
        logic exp;
        for (int dir = 1; dir >= 0; dir--) begin
            raw_a2 = dir[0];
            for (int i = 1; i <= 6; i++) begin
                tick();
`ifdef INPUT_COND_PULSE_EN
                exp = dir[0] && (i == 5);
`else
                exp = (i >= 5) ? dir[0] : ~dir[0];
`endif
                checks++;
                if (a_out2 !== exp || a_bounce2 !== 1'b0) begin
                    failures++;
                    $display("FAIL fast_cfg dir%0d edge%0d: a_out=%b a_bounce=%b expected %b 0", dir, i, a_out2, a_bounce2, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_bounce();
        test_simultaneous();
        test_reset_mid_check();
        test_high_through_reset();
        test_pulse_mode();
        test_fast_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_input_conditioner
`default_nettype wire
